noc_local_ingress_buffer: RTL
=============================

Name: noc_local_ingress_buffer

Overview:
- Local-port ingress stage between a node's flit sender and the router's local input port.
- Buffers flits in a show-ahead FIFO and checks packet framing: a packet starts with a header flit and ends with a tail flit.
- Discards stray flits that arrive outside a packet and reports framing errors.
- Presents clean packets to the router using the same valid/ready/is_header/is_tail flit interface.

Parameters:
- DATA_WIDTH, `Noc_Data_Width: flit width in bits.
- DEPTH, 8: FIFO entries; must be a power of two, at least 2.
- CNT_WIDTH, 16: width of the error counters.

Ports:
- noc_clk  in  1  sole clock; all logic on the rising edge.
- noc_rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  flit from the node is valid.
- in_ready  out  1  buffer can accept a flit this cycle.
- in_flit  in  DATA_WIDTH  flit payload.
- in_is_header  in  1  flit is a packet header.
- in_is_tail  in  1  flit is a packet tail.
- out_valid  out  1  flit available to the router.
- out_ready  in  1  router accepts the flit.
- out_flit  out  DATA_WIDTH  head-of-FIFO flit.
- out_is_header  out  1  header flag of the head entry.
- out_is_tail  out  1  tail flag of the head entry.
- fifo_level  out  $clog2(DEPTH)+1  number of occupied entries.
- drop_cnt  out  CNT_WIDTH  saturating count of discarded flits.
- frame_err  out  1  one-cycle pulse on any framing violation.

Behaviour:
- Reset (async, noc_rst=1):
  - Pointers, fifo_level, drop_cnt, frame_err and out_valid all go to 0.
  - Framing FSM goes to EXPECT_HDR.
  - in_ready is 1 once the FIFO is empty after reset.
  - FIFO contents are not cleared. out_flit, out_is_header and out_is_tail are don't-care while out_valid=0.
- Reset mid-packet: the FIFO is flushed, the partial packet is lost and the FSM restarts in EXPECT_HDR.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = (fifo_level != DEPTH), combinational from occupancy only. There is no bypass: when full, in_ready=0 even if a pop occurs in the same cycle.
  - out_valid = (fifo_level != 0).
- Latency: a flit written on edge N appears on out_* after edge N; it can be consumed at edge N+1. Show-ahead: out_* reflect the head entry combinationally from storage.
- Stored entry = {is_header, is_tail, flit}. Output order is identical to accepted order.
- Framing FSM, evaluated only on input transfers:
  - EXPECT_HDR:
    - header && tail (single-flit packet): store; stay.
    - header only: store; go to IN_PKT.
    - non-header: do not store; increment drop_cnt; pulse frame_err.
  - IN_PKT:
    - tail (header=0): store; go to EXPECT_HDR.
    - body flit: store; stay.
    - header: store it as the start of a new packet; pulse frame_err; drop_cnt unchanged; stay in IN_PKT, or go to EXPECT_HDR if tail is also set. The prior packet remains unterminated, and the router must tolerate this.
  - A dropped flit still completes the handshake (in_ready was 1). It does not change fifo_level.
- Simultaneous push and pop (non-full, non-empty): fifo_level is unchanged and both pointers advance.
- Push into an empty FIFO with out_ready=1: no same-cycle bypass; out_valid rises the next cycle.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fifo_level is tracked by a separate counter.
- drop_cnt saturates at all-ones and never wraps.
- frame_err is registered and high for exactly one cycle per offending flit.
- in_* are ignored when in_valid=0. out_* must hold stable while out_valid && !out_ready.

Test Plan:
- Packet pass-through: header, body 0xFF..F, tail sent with out_ready=1 → out shows the 3 flits in order, flags 10/00/01, one cycle after each accept; fifo_level returns to 0; drop_cnt=0.
- Backpressure fill: out_ready=0 while 10 flits are offered with DEPTH=8 → in_ready falls after the 8th accept, fifo_level=8; raise out_ready → all 8 drain in order, in_ready rises after the first pop.
- Stray flits: two body flits with no header while in EXPECT_HDR → nothing stored, drop_cnt=2, two frame_err pulses; then a valid 3-flit packet passes intact.
- Header inside packet: header, body, header, body, tail → all 5 stored and output, a single frame_err pulse on the 2nd header, drop_cnt=0, FSM ends in EXPECT_HDR.
- Wrap and concurrency: continuous push/pop of 20 single-flit packets (header and tail both set) with out_ready=1 → fifo_level stays at or below 1, data is matched in order across pointer wrap, no errors.
- Reset mid-packet: assert noc_rst after the header and one body flit are accepted → out_valid=0 and fifo_level=0 immediately; after release, a lone tail flit is dropped with drop_cnt=1.

Source files
------------

// File: rtl/noc_local_ingress_buffer.sv
// Local-port ingress buffer: show-ahead flit FIFO that checks packet framing.
// Flits arriving outside a packet are dropped and counted.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_local_ingress_buffer #(
    parameter int DATA_WIDTH = `Noc_Data_Width,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     noc_clk,
    input  logic                     noc_rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_flit,
    input  logic                     in_is_header,
    input  logic                     in_is_tail,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_flit,
    output logic                     out_is_header,
    output logic                     out_is_tail,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_WIDTH-1:0]     drop_cnt,
    output logic                     frame_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic                  hdr;
        logic                  tail;
        logic [DATA_WIDTH-1:0] flit;
    } entry_t;

    typedef enum logic {EXPECT_HDR, IN_PKT} state_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    state_t             state, state_nxt;
    logic               in_xfer, out_xfer, push, drop, err;
    entry_t             head;

    assign in_ready  = (fifo_level != LVL_W'(DEPTH));
    assign out_valid = (fifo_level != '0);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    assign head          = mem[rd_ptr];
    assign out_flit      = head.flit;
    assign out_is_header = head.hdr;
    assign out_is_tail   = head.tail;

    // Framing decisions only happen on accepted input flits.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        drop      = 1'b0;
        err       = 1'b0;
        if (in_xfer) begin
            case (state)
                EXPECT_HDR: begin
                    if (in_is_header) begin
                        push = 1'b1;
                        if (!in_is_tail) state_nxt = IN_PKT;
                    end else begin
                        drop = 1'b1;
                        err  = 1'b1;
                    end
                end
                IN_PKT: begin
                    push = 1'b1;
                    // A header here opens a new packet; the old one stays unterminated.
                    if (in_is_header) err = 1'b1;
                    if (in_is_tail) state_nxt = EXPECT_HDR;
                end
                default: state_nxt = EXPECT_HDR;
            endcase
        end
    end

    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state      <= EXPECT_HDR;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_cnt   <= '0;
            frame_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_err <= err;
            if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
            if (out_xfer) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !out_xfer)      fifo_level <= fifo_level + LVL_W'(1);
            else if (!push && out_xfer) fifo_level <= fifo_level - LVL_W'(1);
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
        end
    end

    // Storage is not reset; out_* are only meaningful while out_valid is high.
    always_ff @(posedge noc_clk) begin
        if (push) mem[wr_ptr] <= '{hdr: in_is_header, tail: in_is_tail, flit: in_flit};
    end
endmodule
